hnf_txsnp_arb: RTL
==================

# hnf_txsnp_arb

Snoop-request arbiter in the HN-F, sitting between the snoop sources (MSHR snoop issue, snoop-filter back-invalidation, and other sources) and the TXSNP flit wrapper. It selects one pending snoop request per cycle using QoS priority, round-robin tie-break and starvation escalation. It registers the winner onto a single valid/busy output port and returns a one-cycle acknowledge to the winning source when the wrapper accepts it.

## Interface
- REQ_NUM, 2: number of snoop requesters (2..8).
- PAYLOAD_WIDTH, 128: opaque snoop field bundle (opcode, addr, txnid, fwd fields, ns, rettosrc, tracetag).
- RNF_NUM, 4: width of the RN-F target vector.
- QOS_WIDTH, 4: QoS field width.
- STARVE_LIMIT, 8: number of lost acceptances after which a waiting requester escalates (1..15).
- clk  in  1  clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req_valid  in  REQ_NUM  request pending per source; held until req_ack.
- req_qos  in  REQ_NUM*QOS_WIDTH  per-source QoS, slice i at [i*QOS_WIDTH +: QOS_WIDTH].
- req_payload  in  REQ_NUM*PAYLOAD_WIDTH  per-source snoop fields.
- req_rn_vec  in  REQ_NUM*RNF_NUM  per-source snoop target vector.
- req_ack  out  REQ_NUM  one-hot, one-cycle pulse: request accepted downstream.
- out_valid  out  1  snoop request presented to the TXSNP wrapper.
- out_qos / out_payload / out_rn_vec  out  QOS_WIDTH / PAYLOAD_WIDTH / RNF_NUM  registered copy of the winning request.
- out_grant_id  out  clog2(REQ_NUM) (min 1)  index of the presented source.
- out_busy  in  1  wrapper cannot accept this cycle (covers credit or fan-out in progress).

## Operation
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- accept = (state==HOLD) & ~out_busy. On accept, req_ack[out_grant_id]=1 combinationally in the same cycle. req_ack is 0 otherwise.
- Candidates = req_valid, with the source being acked this cycle masked out. A candidate is also masked if it is currently presented and not yet accepted.
- Selection tiers, in order:
  - (1) starved candidates (wait_cnt==STARVE_LIMIT);
  - (2) otherwise the candidates with the maximum req_qos;
  - within the tier, the first index at or after rr_ptr, wrapping modulo REQ_NUM.
- Transitions:
  - IDLE with any candidate → HOLD: winner fields and index registered.
  - HOLD with accept and a candidate → HOLD: new winner registered, back-to-back with no bubble.
  - HOLD with accept and no candidate → IDLE.
  - HOLD with out_busy=1 → HOLD: output registers frozen; no re-arbitration, even if a higher-QoS request arrives.
- rr_ptr: on accept, becomes (out_grant_id+1) mod REQ_NUM. Wrap from REQ_NUM-1 gives 0.
- wait_cnt[i] (4 bits):
  - cleared when req_valid[i]=0 or req_ack[i]=1;
  - else incremented by 1 on each accept of another source, saturating at STARVE_LIMIT.
- Payload is captured at selection. Source-side changes after capture are ignored until ack.
- Requester protocol violation (req_valid dropped before ack): presented copy still forwarded, ack still pulses; no error flag.

## Timing
- Reset values: out_valid=0, out_qos=0, out_payload=0, out_rn_vec=0, out_grant_id=0, req_ack=0, rr_ptr=0, all wait_cnt=0, state=IDLE.
- Latency: req_valid rising at cycle N (idle arbiter) → out_valid=1 at N+1. Ack occurs in the first cycle ≥N+1 with out_busy=0.
- Throughput: one acceptance per cycle when different sources alternate. The same source cannot be re-presented in its ack cycle, so it has a minimum one-cycle gap between its own acks.
- out_busy is sampled only in HOLD; its value in IDLE is ignored.
- Reset mid-operation: at the rst edge all state returns to reset values and no ack is issued for the dropped request. The source still holds valid, so it is re-arbitrated after rst deasserts.

## Test plan
- Single request: REQ_NUM=2, req_valid=01, qos=3, out_busy=0.
  - out_valid at +1 cycle, out_grant_id=0, req_ack=01 same cycle, IDLE next.
- Equal-QoS round robin: both sources valid continuously, qos=0, out_busy=0.
  - Grants alternate 0,1,0,1; out_valid stays 1 with no bubbles; rr_ptr wraps 1→0.
- QoS priority and hold: source0 qos=2 presented with out_busy=1 for 5 cycles; source1 raises qos=15 meanwhile.
  - out_payload unchanged during the stall; source0 acked first; source1 presented on the next cycle.
- Starvation: REQ_NUM=3, STARVE_LIMIT=2, sources 0 and 1 at qos=15 continuously, source2 at qos=0.
  - Source2 is granted on the acceptance after its 2nd loss, i.e. the third output presentation.
- Backpressure plus reset: out_busy=1 with a request in HOLD, then rst for 1 cycle.
  - Next cycle all outputs are 0 with no req_ack; one cycle after rst deasserts, the request is presented again with out_grant_id reset-consistent (rr_ptr=0).

Source files
------------

// File: rtl/hnf_txsnp_arb.sv
// Purpose: HN-F TXSNP snoop arbiter; picks one snoop source per cycle (starvation > QoS > round robin).
// Latency: a request seen in cycle N is presented registered at N+1; req_ack is combinational on acceptance.
// Backpressure: out_busy freezes the presented request and all arbitration state until it drops.
module hnf_txsnp_arb #(
  parameter int REQ_NUM       = 2,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int RNF_NUM       = 4,
  parameter int QOS_WIDTH     = 4,
  parameter int STARVE_LIMIT  = 8,
  localparam int GW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_NUM-1:0]               req_valid,
  input  logic [REQ_NUM*QOS_WIDTH-1:0]     req_qos,
  input  logic [REQ_NUM*PAYLOAD_WIDTH-1:0] req_payload,
  input  logic [REQ_NUM*RNF_NUM-1:0]       req_rn_vec,
  output logic [REQ_NUM-1:0]               req_ack,
  output logic                             out_valid,
  output logic [QOS_WIDTH-1:0]             out_qos,
  output logic [PAYLOAD_WIDTH-1:0]         out_payload,
  output logic [RNF_NUM-1:0]               out_rn_vec,
  output logic [GW-1:0]                    out_grant_id,
  input  logic                             out_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Registered copy of the winning request as handed to the TXSNP wrapper.
  typedef struct packed {
    logic [QOS_WIDTH-1:0]     qos;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [RNF_NUM-1:0]       rn_vec;
  } snp_t;

  localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [GW-1:0] LAST_IDX = GW'(REQ_NUM - 1);

  state_t               state_q;
  state_t               state_d;
  snp_t                 out_q;
  snp_t                 win;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        rr_q;
  logic [GW-1:0]        win_idx;
  logic [3:0]           wait_q [REQ_NUM];
  logic [3:0]           wait_d [REQ_NUM];
  logic                 accept;
  logic                 any_cand;
  logic                 load;
  logic [REQ_NUM-1:0]   pres_mask;
  logic [REQ_NUM-1:0]   cand;
  logic [REQ_NUM-1:0]   starved;
  logic [REQ_NUM-1:0]   top_qos;
  logic [REQ_NUM-1:0]   tier;
  logic [QOS_WIDTH-1:0] max_qos;

  // First set bit of m at or after ptr, wrapping to the lowest set bit.
  function automatic logic [GW-1:0] rr_pick(input logic [REQ_NUM-1:0] m,
                                            input logic [GW-1:0]      ptr);
    logic [GW-1:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int j = 0; j < REQ_NUM; j++) begin
      if (!found && m[j] && (GW'(j) >= ptr)) begin
        r     = GW'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < REQ_NUM; j++) begin
      if (!found && m[j]) begin
        r     = GW'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign accept = (state_q == HOLD) && !out_busy;

  // Presented-source mask; the ack is that mask gated by acceptance. The presented
  // source is never a candidate: either it is being acked or it is stalled in HOLD.
  always_comb begin
    pres_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      pres_mask[i] = (state_q == HOLD) && (grant_q == GW'(i));
    end
    req_ack = pres_mask & {REQ_NUM{accept}};
    cand    = req_valid & ~pres_mask;
  end

  // Next wait counts. Starvation is judged on the count this source will hold after
  // the current acceptance, so a source suffering its LIMIT-th loss wins the same edge.
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      wait_d[i] = wait_q[i];
      if (!req_valid[i] || req_ack[i]) begin
        wait_d[i] = 4'd0;
      end else if (accept && (wait_q[i] != LIMIT)) begin
        wait_d[i] = wait_q[i] + 4'd1;
      end
    end
  end

  // Tiered selection: starved candidates first, else those at the highest QoS, then round robin.
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (cand[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)) begin
        max_qos = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
      end
    end
    starved = '0;
    top_qos = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      starved[i] = cand[i] && (wait_d[i] == LIMIT);
      top_qos[i] = cand[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
    end
    tier     = (|starved) ? starved : top_qos;
    any_cand = |cand;
    win_idx  = rr_pick(tier, rr_q);
  end

  // Mux the winning source's fields for capture.
  always_comb begin
    win = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (win_idx == GW'(i)) begin
        win.qos     = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
        win.payload = req_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        win.rn_vec  = req_rn_vec[i*RNF_NUM +: RNF_NUM];
      end
    end
  end

  // Next state and capture strobe; a stalled HOLD keeps everything frozen.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_cand) begin
          state_d = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          if (any_cand) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers and round-robin pointer; pointer moves past the accepted source.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      if (load) begin
        out_q   <= win;
        grant_q <= win_idx;
      end
      if (accept) begin
        rr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);
      end
    end
  end

  // Per-source starvation counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (rst) begin
        wait_q[i] <= 4'd0;
      end else begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign out_qos      = out_q.qos;
  assign out_payload  = out_q.payload;
  assign out_rn_vec   = out_q.rn_vec;
  assign out_grant_id = grant_q;

endmodule
